dmem_access_unit: RTL and testbench
===================================

DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 6; word-address width, DEPTH = 2^ADDR_W words of 32 bits.
REQ-002 SHALL have parameter SCAN_DIV, default 20000000; clk cycles per debug scan step.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  access request present.
REQ-006 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 SHALL have port req_signed  input  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 SHALL have port req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2]; higher bits ignored.
REQ-011 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid  output  1  one-cycle pulse per accepted request.
REQ-013 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  misaligned/illegal flag, qualified by rsp_valid.
REQ-015 SHALL have port clear_start  input  1  request full memory zero-fill.
REQ-016 SHALL have port clear_busy  output  1  high while zero-fill in progress.
REQ-017 SHALL have port dbg_mode  input  1  1 = auto-scan, 0 = manual debug address.
REQ-018 SHALL have port dbg_addr  input  ADDR_W  manual debug word address.
REQ-019 SHALL have port dbg_addr_cur  output  ADDR_W  debug address currently displayed.
REQ-020 SHALL have port dbg_data  output  32  registered contents of mem[dbg_addr_cur].

Function
REQ-021 SHALL implement FSM states IDLE and CLEAR; req_ready = (state==IDLE) && !clear_start.
REQ-022 SHALL, in IDLE with clear_start high, enter CLEAR with clear pointer 0; clear_start takes priority over a same-cycle req_valid (not accepted).
REQ-023 SHALL, in CLEAR, write 0 to mem[ptr] each cycle, increment ptr, and return to IDLE the cycle after writing DEPTH-1 (DEPTH cycles total); clear_start ignored in CLEAR.
REQ-024 SHALL drive clear_busy = (state==CLEAR).
REQ-025 SHALL treat size 01 with addr[0]=1, size 10 with addr[1:0]!=0, and size 11 as errors: no memory write, rsp_err=1, rsp_rdata=0.
REQ-026 SHALL, on accepted legal store, write at that edge only the addressed lanes: byte lane addr[1:0], half lanes addr[1]*2..+1, word all four; other bytes unchanged.
REQ-027 SHALL, on accepted legal load, present rsp_rdata exactly one cycle after acceptance, selected lane extended per req_signed.
REQ-028 SHALL assert rsp_valid one cycle after every accepted request (load, store or error), else 0; back-to-back requests give back-to-back pulses.
REQ-029 SHALL return newly written data to a load accepted the cycle after a store to the same word.
REQ-030 SHALL, when dbg_mode=1, count 0..SCAN_DIV-1; on wrap advance scan address by 1, DEPTH-1 wrapping to 0.
REQ-031 SHALL, when dbg_mode=0, hold count and scan address at 0 and set dbg_addr_cur = dbg_addr.
REQ-032 SHALL register dbg_data <= mem[dbg_addr_cur] every cycle (one-cycle latency), independent of FSM state.

Reset
REQ-033 SHALL, on reset low, asynchronously set state IDLE, clear pointer 0, scan count 0, scan address 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, dbg_data 0.
REQ-034 SHALL NOT initialise memory contents on reset; reset during CLEAR aborts the fill, remaining words keep old values.

Verification
REQ-035 SHALL verify: clear_start, wait DEPTH cycles -> clear_busy high exactly 64 cycles, all words read 0.
REQ-036 SHALL verify: store word 0x11223344 @0x10, store byte 0xAA @0x11 -> load word @0x10 returns 0x1122AA44 one cycle later.
REQ-037 SHALL verify: mem[4]=0x0000FF80; signed byte load @0x10 -> 0xFFFFFF80; unsigned -> 0x00000080; signed half @0x12 -> 0x00000000.
REQ-038 SHALL verify: store half @0x13 -> rsp_err=1, rsp_rdata=0, mem[4] unchanged; size 11 -> rsp_err=1.
REQ-039 SHALL verify with SCAN_DIV=4, dbg_mode=1: dbg_addr_cur increments every 4 cycles, 63 -> 0; dbg_mode=0 -> dbg_addr_cur follows dbg_addr.
REQ-040 SHALL verify: reset asserted mid-CLEAR -> clear_busy 0 immediately, rsp_valid 0, req_ready 1 after release.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: load/store request and response bus of dmem_access_unit.
interface dmem_access_unit_if;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    modport master(output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
                   input req_ready, rsp_valid, rsp_err, rsp_rdata);
    modport slave(input req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_err, rsp_rdata);
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: byte/half/word data memory with zero-fill engine and debug scan port.
module dmem_access_unit #(
    parameter int ADDR_W   = 6,
    parameter int SCAN_DIV = 20000000
) (
    input  logic              clk,
    input  logic              reset,
    dmem_access_unit_if.slave bus,
    input  logic              clear_start,
    output logic              clear_busy,
    input  logic              dbg_mode,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [ADDR_W-1:0] dbg_addr_cur,
    output logic [31:0]       dbg_data
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state, state_n;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] ptr, scan, widx;
    logic [CW-1:0]     cnt;
    logic              acc, err, st_we, wrap;
    logic [1:0]        off, sz;
    logic [3:0]        be;
    logic [31:0]       wd, sh, ld;

    assign bus.req_ready = state == IDLE && !clear_start;
    assign clear_busy    = state == CLEAR;
    assign dbg_addr_cur  = dbg_mode ? scan : dbg_addr;
    assign wrap          = cnt == CW'(SCAN_DIV - 1);

    always_comb begin
        state_n = state;
        if (state == IDLE && clear_start) state_n = CLEAR;
        else if (state == CLEAR && ptr == ADDR_W'(DEPTH - 1)) state_n = IDLE;
    end

    always_comb begin
        off   = bus.req_addr[1:0];
        sz    = bus.req_size;
        widx  = ADDR_W'(bus.req_addr >> 2);
        acc   = bus.req_valid && bus.req_ready;
        err   = sz == 2'd3 || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
        st_we = acc && bus.req_we && !err && reset;
        be    = sz == 2'd0 ? 4'b0001 << off : sz == 2'd1 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd    = sz == 2'd0 ? {4{bus.req_wdata[7:0]}} : sz == 2'd1 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
        // Lane shifted down to bit 0; legal word accesses have off==0 so sh is the whole word.
        sh    = mem[widx] >> {off, 3'b000};
        ld    = sz == 2'd0 ? {{24{bus.req_signed && sh[7]}}, sh[7:0]}
              : sz == 2'd1 ? {{16{bus.req_signed && sh[15]}}, sh[15:0]} : sh;
    end

    // Memory contents are deliberately outside reset so an aborted fill leaves old data.
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[ptr] <= '0;
        else if (st_we)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            scan          <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            dbg_data      <= '0;
        end else begin
            state         <= state_n;
            ptr           <= state == CLEAR ? ptr + 1'b1 : '0;
            cnt           <= !dbg_mode || wrap ? '0 : cnt + 1'b1;
            scan          <= !dbg_mode ? '0 : wrap ? scan + 1'b1 : scan;
            bus.rsp_valid <= acc;
            bus.rsp_err   <= acc && err;
            bus.rsp_rdata <= acc && !bus.req_we && !err ? ld : '0;
            dbg_data      <= mem[dbg_addr_cur];
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: vector table, directed corner sequences and random traffic against a byte-array model.
module tb_dmem_access_unit;
    localparam int AW = 6;
    localparam int DEPTH = 64;
    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr, wdata, exp_rd;
        logic        exp_err;
    } vec_t;

    logic          clk = 0, reset = 0, clear_start = 0, clear_busy, dbg_mode = 0;
    logic [AW-1:0] dbg_addr = 0, dbg_addr_cur;
    logic [31:0]   dbg_data;
    int            errors = 0, checks = 0;
    logic [7:0]    mb [DEPTH*4];
    vec_t          tbl [$];

    dmem_access_unit_if bus();
    dmem_access_unit #(.ADDR_W(AW), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .bus(bus), .clear_start(clear_start), .clear_busy(clear_busy),
        .dbg_mode(dbg_mode), .dbg_addr(dbg_addr), .dbg_addr_cur(dbg_addr_cur), .dbg_data(dbg_data));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model memory is a flat little-endian byte array of DEPTH*4 bytes.
    task automatic m_access(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int n = 1 << size;
        int a = int'(addr % (DEPTH * 4));
        rd = 0;
        er = size == 3 || (a % n) != 0;
        if (er) return;
        if (we) for (int i = 0; i < n; i++) mb[a+i] = wdata[8*i +: 8];
        else begin
            for (int i = 0; i < n; i++) rd |= 32'(mb[a+i]) << (8 * i);
            if (sgn && n < 4 && rd[8*n-1]) rd |= 32'hFFFF_FFFF << (8 * n);
        end
    endtask

    function automatic logic [31:0] m_word(input int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    function automatic vec_t v(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        vec_t r;
        r.we = we; r.size = size; r.sgn = sgn; r.addr = addr; r.wdata = wdata; r.exp_rd = exp_rd; r.exp_err = exp_err;
        return r;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        bus.req_valid = 1; bus.req_we = we; bus.req_size = size; bus.req_signed = sgn;
        bus.req_addr = addr; bus.req_wdata = wdata;
        #1 chk("req_ready", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 0;
        chk("rsp_valid", bus.rsp_valid, 1);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
    endtask

    task automatic dump_check(input string nm);
        dbg_mode = 0;
        for (int w = 0; w < DEPTH; w++) begin
            dbg_addr = AW'(w);
            @(negedge clk);
            chk(nm, dbg_data, m_word(w));
        end
    endtask

    initial begin
        logic [31:0] rd, mrd, a;
        logic        er, mer;
        logic [1:0]  sz;
        int          busy;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;
        repeat (2) @(negedge clk);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset rsp_err", bus.rsp_err, 0);
        chk("reset rsp_rdata", bus.rsp_rdata, 0);
        chk("reset dbg_data", dbg_data, 0);
        chk("reset clear_busy", clear_busy, 0);
        reset = 1;
        @(negedge clk);

        // Zero-fill; a same-cycle store must lose to clear_start.
        clear_start = 1;
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2; bus.req_addr = 0; bus.req_wdata = 32'hDEAD_BEEF;
        #1 chk("req_ready vs clear_start", bus.req_ready, 0);
        @(negedge clk);
        clear_start = 0; bus.req_valid = 0;
        chk("rsp_valid not accepted", bus.rsp_valid, 0);
        busy = clear_busy ? 1 : 0;
        for (int k = 0; k < 200 && clear_busy; k++) begin
            @(negedge clk);
            if (clear_busy) busy++;
        end
        chk("clear_busy cycles", busy, DEPTH);
        foreach (mb[i]) mb[i] = 0;
        dump_check("cleared word");

        tbl.push_back(v(1, 2, 0, 32'h10, 32'h1122_3344, 0, 0));
        tbl.push_back(v(1, 0, 0, 32'h11, 32'h0000_00AA, 0, 0));
        tbl.push_back(v(0, 2, 0, 32'h10, 0, 32'h1122_AA44, 0));
        tbl.push_back(v(1, 2, 0, 32'h10, 32'h0000_FF80, 0, 0));
        tbl.push_back(v(0, 0, 1, 32'h10, 0, 32'hFFFF_FF80, 0));
        tbl.push_back(v(0, 0, 0, 32'h10, 0, 32'h0000_0080, 0));
        tbl.push_back(v(0, 1, 1, 32'h12, 0, 32'h0000_0000, 0));
        tbl.push_back(v(1, 1, 0, 32'h13, 32'h0000_BEEF, 0, 1));
        tbl.push_back(v(0, 2, 0, 32'h10, 0, 32'h0000_FF80, 0));
        tbl.push_back(v(1, 3, 0, 32'h10, 32'h1234_5678, 0, 1));
        tbl.push_back(v(0, 3, 1, 32'h10, 0, 0, 1));
        tbl.push_back(v(0, 1, 1, 32'h10, 0, 32'hFFFF_FF80, 0));
        tbl.push_back(v(0, 1, 0, 32'h10, 0, 32'h0000_FF80, 0));
        tbl.push_back(v(0, 2, 0, 32'h12, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 32'h22, 32'h5555_8001, 0, 0));
        tbl.push_back(v(0, 2, 0, 32'h20, 0, 32'h8001_0000, 0));
        tbl.push_back(v(0, 2, 0, 32'hF000_0110, 0, 32'h0000_FF80, 0));
        tbl.push_back(v(0, 0, 1, 32'h23, 0, 32'hFFFF_FF80, 0));
        foreach (tbl[i]) begin
            do_req(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, rd, er);
            m_access(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, mrd, mer);
            chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d err", i), er, tbl[i].exp_err);
        end

        // Back-to-back store then load of the same word.
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2; bus.req_signed = 0; bus.req_addr = 32'h30; bus.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("b2b store valid", bus.rsp_valid, 1);
        chk("b2b store err", bus.rsp_err, 0);
        bus.req_we = 0;
        @(negedge clk);
        bus.req_valid = 0;
        chk("b2b load valid", bus.rsp_valid, 1);
        chk("b2b load data", bus.rsp_rdata, 32'hCAFE_F00D);
        m_access(1, 2, 0, 32'h30, 32'hCAFE_F00D, mrd, mer);
        @(negedge clk);
        chk("idle rsp_valid", bus.rsp_valid, 0);

        for (int i = 0; i < 300; i++) begin
            int gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                chk("rand idle rsp_valid", bus.rsp_valid, 0);
            end
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = sz == 1 ? {a[1], 1'b0} : sz == 2 ? 2'b00 : a[1:0];
            begin
                logic        we = 1'($urandom_range(0, 1));
                logic        sg = 1'($urandom_range(0, 1));
                logic [31:0] wd = $urandom;
                do_req(we, sz, sg, a, wd, rd, er);
                m_access(we, sz, sg, a, wd, mrd, mer);
            end
            chk("rand rdata", rd, mrd);
            chk("rand err", er, mer);
        end

        for (int w = 0; w < DEPTH; w++) begin
            logic [31:0] wd = $urandom | 32'h1;
            do_req(1, 2, 0, {$urandom_range(0, 255), 24'h0} | 32'(w * 4), wd, rd, er);
            m_access(1, 2, 0, 32'(w * 4), wd, mrd, mer);
        end

        // Auto-scan with SCAN_DIV=4, including the 63 -> 0 wrap.
        dbg_mode = 1;
        #1 chk("scan start", dbg_addr_cur, 0);
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            chk("scan addr", dbg_addr_cur, 32'((k / 4) % DEPTH));
            chk("scan data", dbg_data, m_word(((k - 1) / 4) % DEPTH));
        end
        dbg_mode = 0; dbg_addr = 17;
        #1 chk("manual addr", dbg_addr_cur, 17);
        @(negedge clk);
        chk("manual data", dbg_data, m_word(17));
        dbg_addr = 42;
        #1 chk("manual addr2", dbg_addr_cur, 42);
        @(negedge clk);
        dbg_mode = 1;
        #1 chk("scan held at 0", dbg_addr_cur, 0);
        @(negedge clk);
        dbg_mode = 0;

        // Abort a fill after 10 words by reset.
        clear_start = 1;
        @(negedge clk);
        clear_start = 0;
        repeat (10) @(negedge clk);
        chk("busy mid clear", clear_busy, 1);
        reset = 0;
        #1 chk("reset clear_busy", clear_busy, 0);
        chk("reset rsp_valid mid", bus.rsp_valid, 0);
        @(negedge clk);
        reset = 1;
        #1 chk("req_ready after reset", bus.req_ready, 1);
        chk("clear_busy after reset", clear_busy, 0);
        for (int i = 0; i < 40; i++) mb[i] = 0;
        dump_check("partial clear word");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
